fm_sb_freeze_monitor: RTL
=========================

Name: fm_sb_freeze_monitor

Overview:
Responder side of the spy-buffer freeze control path. Takes the per-buffer freeze request vector driven toward the spy buffers and the freeze acknowledges returned by them. Runs a global freeze handshake state machine with timeout and builds the status words and error flags mapped into the FM monitor register block.

Parameters:
SB_N, 64, number of mapped spy buffers; legal range 1..64.
TIMEOUT_CYCLES, 1024, cycles allowed for acknowledge collection or release before a timeout; must be ≥2.
CNT_W, 16, width of the freeze episode counter.

Ports:
axi_clk  in  1  register-domain clock.
axi_rst_n  in  1  asynchronous, active-low reset.
freeze_req  in  SB_N  per-buffer freeze request, already masked.
freeze_ack  in  SB_N  per-buffer "frozen" acknowledge from the spy buffers, synchronous to axi_clk.
clear_err  in  1  single-cycle pulse; clears sticky errors.
freeze_status_0  out  32  bits 0..31: registered freeze_req & freeze_ack.
freeze_status_1  out  32  bits 32..63 of the same; unused bits read 0.
unexpected_ack  out  64  sticky: freeze_ack set while matching freeze_req is 0; bits ≥SB_N read 0.
all_frozen  out  1  high only in FROZEN.
timeout_err  out  1  sticky timeout flag.
fsm_state  out  3  encoded state: IDLE=0, WAIT_ACK=1, FROZEN=2, RELEASE=3, TIMEOUT=4.
freeze_count  out  CNT_W  completed freeze episodes (WAIT_ACK→FROZEN transitions); saturates at all-ones.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; timer 0.
- Inputs are used directly (no sync stage). All outputs are registered, 1-cycle latency from input sample.
- req_all = (freeze_req != 0); acked = ((freeze_ack & freeze_req) == freeze_req); ack_none = (freeze_ack == 0).
- IDLE: if req_all → WAIT_ACK; timer loaded with TIMEOUT_CYCLES-1.
- WAIT_ACK, with priority top-down:
  - !req_all → RELEASE, timer reloaded.
  - acked → FROZEN; freeze_count increments.
  - timer==0 → TIMEOUT; timeout_err set.
  - otherwise timer decrements.
- FROZEN:
  - !req_all → RELEASE, timer reloaded.
  - A new request bit rising (freeze_req & ~req_q ≠ 0, req_q = previous-cycle freeze_req) → WAIT_ACK, timer reloaded.
  - An ack falling while its request is still high → WAIT_ACK, timer reloaded.
- RELEASE:
  - req_all → WAIT_ACK, timer reloaded (re-freeze preempts release).
  - ack_none → IDLE.
  - timer==0 → TIMEOUT; timeout_err set.
- TIMEOUT: exits to IDLE when !req_all and ack_none, checked every cycle. timeout_err stays set.
- Simultaneous events:
  - In WAIT_ACK, when acked and timer==0 occur in the same cycle, FROZEN wins.
  - When clear_err and a new timeout occur in the same cycle, timeout_err ends at 1.
  - clear_err also clears unexpected_ack, except for bits re-detected in the same cycle, which stay set.
- freeze_count does not wrap: it holds at 2^CNT_W-1.
- Bits ≥SB_N of all vectors are tied 0.
- Reset asserted mid-episode: immediate return to IDLE and all outputs 0, regardless of the acks still present.

Optional Feature:
FM_SB_FREEZE_LATENCY_EN:
- Defined: adds output freeze_lat_max (16 bits, port placed after freeze_count).
  - Counts cycles from entering WAIT_ACK to entering FROZEN; the count saturates at 0xFFFF.
  - On each FROZEN entry, freeze_lat_max captures the count if it exceeds the stored value.
  - Cleared by reset and by clear_err.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Timed acknowledge: SB_N=64, TIMEOUT_CYCLES=16. freeze_req=all-ones, freeze_ack follows 5 cycles later → fsm_state 1 then 2. all_frozen=1, freeze_count=1, both status words 0xFFFFFFFF, timeout_err=0.
- Missing acknowledge: freeze_req bit 40 only, no ack → TIMEOUT after 16 cycles in WAIT_ACK; timeout_err=1. Drop freeze_req → IDLE; timeout_err stays 1 until a clear_err pulse → 0.
- Stray acknowledge: freeze_req=0, freeze_ack bit 3 pulsed one cycle → unexpected_ack=0x8 sticky, fsm_state stays 0. clear_err → 0.
- Release and re-freeze: from FROZEN, drop freeze_req → RELEASE. Reassert freeze_req before the acks drop → WAIT_ACK; freeze_count=2 after the acks return.
- Reset mid-operation: assert axi_rst_n=0 in WAIT_ACK while bit 7 is acked → all outputs 0 asynchronously, IDLE after release.
- Latency (macro defined): two freeze episodes with acks after 5 and 9 cycles → freeze_lat_max=9. A third episode with 3 cycles → freeze_lat_max stays 9.

Source files
------------

// File: rtl/fm_sb_freeze_monitor.sv
// Spy-buffer freeze responder: global freeze handshake FSM with timeout, status words
// and sticky error flags. Optional FM_SB_FREEZE_LATENCY_EN adds a worst-case freeze latency.
module fm_sb_freeze_monitor #(
  parameter int unsigned SB_N           = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             axi_clk,
  input  logic             axi_rst_n,
  input  logic [SB_N-1:0]  freeze_req,
  input  logic [SB_N-1:0]  freeze_ack,
  input  logic             clear_err,
  output logic [31:0]      freeze_status_0,
  output logic [31:0]      freeze_status_1,
  output logic [63:0]      unexpected_ack,
  output logic             all_frozen,
  output logic             timeout_err,
  output logic [2:0]       fsm_state,
  output logic [CNT_W-1:0] freeze_count
`ifdef FM_SB_FREEZE_LATENCY_EN
  ,
  output logic [15:0]      freeze_lat_max
`endif
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TimerReload = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWaitAck = 3'd1,
    StFrozen  = 3'd2,
    StRelease = 3'd3,
    StTimeout = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [63:0]      req_q, ack_q;
  logic [63:0]      status_q, status_d;
  logic [63:0]      unexp_q, unexp_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_set, frz_inc;

  // Zero-extend to the full 64-bit map so bits >= SB_N are tied low everywhere.
  logic [63:0] req_w, ack_w;
  assign req_w = 64'(freeze_req);
  assign ack_w = 64'(freeze_ack);

  logic req_all, acked, ack_none, req_rise, ack_fall;
  assign req_all  = (req_w != '0);
  assign acked    = ((ack_w & req_w) == req_w);
  assign ack_none = (ack_w == '0);
  assign req_rise = |(req_w & ~req_q);
  assign ack_fall = |(ack_q & ~ack_w & req_w);

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      state_q <= StIdle;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    to_set  = 1'b0;
    frz_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_all) begin
          state_d = StWaitAck;
          timer_d = TimerReload;
        end
      end
      StWaitAck: begin
        if (!req_all) begin
          state_d = StRelease;
          timer_d = TimerReload;
        end else if (acked) begin
          state_d = StFrozen;
          frz_inc = 1'b1;
        end else if (timer_q == '0) begin
          state_d = StTimeout;
          to_set  = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StFrozen: begin
        if (!req_all) begin
          state_d = StRelease;
          timer_d = TimerReload;
        end else if (req_rise || ack_fall) begin
          state_d = StWaitAck;
          timer_d = TimerReload;
        end
      end
      StRelease: begin
        if (req_all) begin
          state_d = StWaitAck;
          timer_d = TimerReload;
        end else if (ack_none) begin
          state_d = StIdle;
        end else if (timer_q == '0) begin
          state_d = StTimeout;
          to_set  = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StTimeout: begin
        if (!req_all && ack_none) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fsm_state  = state_q;
    all_frozen = (state_q == StFrozen);
  end

  // Clear first, then OR in same-cycle detections so they survive clear_err.
  always_comb begin
    status_d = req_w & ack_w;
    unexp_d  = (clear_err ? '0 : unexp_q) | (ack_w & ~req_w);
    to_d     = (clear_err ? 1'b0 : to_q) | to_set;
    cnt_d    = (frz_inc && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      req_q    <= '0;
      ack_q    <= '0;
      status_q <= '0;
      unexp_q  <= '0;
      to_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      req_q    <= req_w;
      ack_q    <= ack_w;
      status_q <= status_d;
      unexp_q  <= unexp_d;
      to_q     <= to_d;
      cnt_q    <= cnt_d;
    end
  end

  assign freeze_status_0 = status_q[31:0];
  assign freeze_status_1 = status_q[63:32];
  assign unexpected_ack  = unexp_q;
  assign timeout_err     = to_q;
  assign freeze_count    = cnt_q;

`ifdef FM_SB_FREEZE_LATENCY_EN
  logic [15:0] lat_cnt_q, lat_cnt_d;
  logic [15:0] lat_max_q, lat_max_d;

  // lat_cnt_q holds the number of cycles spent in WAIT_ACK so far, starting at 1.
  always_comb begin
    lat_cnt_d = lat_cnt_q;
    lat_max_d = clear_err ? '0 : lat_max_q;
    if ((state_d == StWaitAck) && (state_q != StWaitAck)) begin
      lat_cnt_d = 16'd1;
    end else if ((state_q == StWaitAck) && (lat_cnt_q != 16'hFFFF)) begin
      lat_cnt_d = lat_cnt_q + 16'd1;
    end
    if (frz_inc && (lat_cnt_q > lat_max_d)) lat_max_d = lat_cnt_q;
  end

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      lat_cnt_q <= '0;
      lat_max_q <= '0;
    end else begin
      lat_cnt_q <= lat_cnt_d;
      lat_max_q <= lat_max_d;
    end
  end

  assign freeze_lat_max = lat_max_q;
`endif

endmodule
